// File: rtl/icdata_fill_if.sv
// Fetch-side read port and memory-side refill port of the i-cache data array.
// master drives requests and beats, slave is the array itself.
interface icdata_fill_if #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned WORD_BITS  = 32
);
  localparam int unsigned SB = $clog2(SETS);
  localparam int unsigned WB = $clog2(LINE_WORDS);
  localparam int unsigned YB = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                      rd_val;
  logic [SB-1:0]             rd_set;
  logic [WB-1:0]             rd_word;
  logic                      rd_rdy;
  logic                      rd_dat_val;
  logic [WAYS*WORD_BITS-1:0] rd_dat;
  logic                      fill_start;
  logic [SB-1:0]             fill_set;
  logic [YB-1:0]             fill_way;
  logic [WB-1:0]             fill_crit;
  logic                      fill_abort;
  logic                      fill_beat_val;
  logic [WORD_BITS-1:0]      fill_beat_dat;
  logic                      fill_beat_rdy;
  logic                      fill_busy;
  logic                      fill_done;

  modport master (
    output rd_val, rd_set, rd_word, fill_start, fill_set, fill_way, fill_crit, fill_abort,
           fill_beat_val, fill_beat_dat,
    input  rd_rdy, rd_dat_val, rd_dat, fill_beat_rdy, fill_busy, fill_done
  );

  modport slave (
    input  rd_val, rd_set, rd_word, fill_start, fill_set, fill_way, fill_crit, fill_abort,
           fill_beat_val, fill_beat_dat,
    output rd_rdy, rd_dat_val, rd_dat, fill_beat_rdy, fill_busy, fill_done
  );
endinterface

// File: rtl/icdata_fill.sv
// Set-associative i-cache data array with a critical-word-first line-fill engine.
// Registered all-ways read; way selection happens downstream in the directory.
`ifndef INFERRED
`define INFERRED 0
`endif
`ifndef DIR_RAM
`define DIR_RAM 1
`endif

module icdata_fill #(
  parameter int unsigned EXPAND_TYPE = `INFERRED,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 64,
  parameter int unsigned LINE_WORDS  = 8,
  parameter int unsigned WORD_BITS   = 32
) (
  input logic          clk,
  input logic          rst,
  icdata_fill_if.slave bus
);
  localparam int unsigned SB = $clog2(SETS);
  localparam int unsigned WB = $clog2(LINE_WORDS);
  localparam int unsigned YB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned AB = SB + WB;
  localparam logic [WB:0] LastCnt = (WB+1)'(LINE_WORDS - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StFill = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [WB:0]               cnt_q, cnt_d;
  logic [SB-1:0]             set_q, set_d;
  logic [YB-1:0]             way_q, way_d;
  logic [WB-1:0]             crit_q, crit_d;
  logic                      done_q, done_d;
  logic                      rd_dat_val_q, rd_dat_val_d;
  logic [WAYS*WORD_BITS-1:0] rd_dat_q, rd_dat_d;

  logic [WORD_BITS-1:0] mem [WAYS][SETS*LINE_WORDS];

  logic          beat_rdy, xfer, rd_acc;
  logic [WB-1:0] wr_word;
  logic [AB-1:0] wr_addr, rd_addr, ram_addr;

  assign beat_rdy = (state_q == StFill) && !bus.fill_abort;
  assign xfer     = bus.fill_beat_val && beat_rdy;
  // WB-bit add wraps the critical-word-first order at the top of the line
  assign wr_word  = crit_q + cnt_q[WB-1:0];
  assign wr_addr  = {set_q, wr_word};
  assign rd_addr  = {bus.rd_set, bus.rd_word};

  if (EXPAND_TYPE == `DIR_RAM) begin : g_dir_ram
    // Single-port macro: a beat steals the address, so the read must retry
    assign bus.rd_rdy = !xfer;
    assign ram_addr   = xfer ? wr_addr : rd_addr;
  end else begin : g_inferred
    assign bus.rd_rdy = 1'b1;
    assign ram_addr   = rd_addr;
  end

  assign rd_acc = bus.rd_val && bus.rd_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    way_d   = way_q;
    crit_d  = crit_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.fill_start && !bus.fill_abort) begin
          state_d = StFill;
          cnt_d   = '0;
          set_d   = bus.fill_set;
          way_d   = bus.fill_way;
          crit_d  = bus.fill_crit;
        end
      end
      StFill: begin
        if (bus.fill_abort) begin
          state_d = StIdle;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_dat_d     = rd_dat_q;
    rd_dat_val_d = rd_acc;
    if (rd_acc) begin
      for (int w = 0; w < WAYS; w++) begin
        // Same-cycle write to the addressed word wins in the fill way
        if (EXPAND_TYPE == `INFERRED && xfer && way_q == YB'(w) && wr_addr == rd_addr) begin
          rd_dat_d[w*WORD_BITS +: WORD_BITS] = bus.fill_beat_dat;
        end else begin
          rd_dat_d[w*WORD_BITS +: WORD_BITS] = mem[w][ram_addr];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      set_q        <= '0;
      way_q        <= '0;
      crit_q       <= '0;
      done_q       <= 1'b0;
      rd_dat_val_q <= 1'b0;
      rd_dat_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      set_q        <= set_d;
      way_q        <= way_d;
      crit_q       <= crit_d;
      done_q       <= done_d;
      rd_dat_val_q <= rd_dat_val_d;
      rd_dat_q     <= rd_dat_d;
    end
  end

  // Array contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (xfer && way_q == YB'(w)) begin
        mem[w][wr_addr] <= bus.fill_beat_dat;
      end
    end
  end

  assign bus.fill_beat_rdy = beat_rdy;
  assign bus.fill_busy     = (state_q == StFill);
  assign bus.fill_done     = done_q;
  assign bus.rd_dat_val    = rd_dat_val_q;
  assign bus.rd_dat        = rd_dat_q;
endmodule

// File: tb/tb_icdata_fill.sv
// Bench for icdata_fill: inferred-array instance for fill/read behaviour plus a
// single-port instance for read/write arbitration. Inputs change on negedge.
`ifndef INFERRED
`define INFERRED 0
`endif
`ifndef DIR_RAM
`define DIR_RAM 1
`endif

module tb_icdata_fill;
  localparam int unsigned WAYS = 2;
  localparam int unsigned SETS = 64;
  localparam int unsigned LW   = 8;
  localparam int unsigned WBIT = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ref_mem [2][512];
  logic [63:0] exp_q [$];
  logic [31:0] exp_dr_q [$];

  icdata_fill_if #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .WORD_BITS(WBIT)) bus ();
  icdata_fill_if #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .WORD_BITS(WBIT)) bus_dr ();

  icdata_fill #(
    .EXPAND_TYPE(`INFERRED), .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .WORD_BITS(WBIT)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  icdata_fill #(
    .EXPAND_TYPE(`DIR_RAM), .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .WORD_BITS(WBIT)
  ) u_dut_dr (
    .clk(clk),
    .rst(rst),
    .bus(bus_dr)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.rd_val = 0; bus.rd_set = '0; bus.rd_word = '0; bus.fill_start = 0; bus.fill_set = '0;
    bus.fill_way = '0; bus.fill_crit = '0; bus.fill_abort = 0; bus.fill_beat_val = 0;
    bus.fill_beat_dat = '0;
    bus_dr.rd_val = 0; bus_dr.rd_set = '0; bus_dr.rd_word = '0; bus_dr.fill_start = 0;
    bus_dr.fill_set = '0; bus_dr.fill_way = '0; bus_dr.fill_crit = '0; bus_dr.fill_abort = 0;
    bus_dr.fill_beat_val = 0; bus_dr.fill_beat_dat = '0;
  endtask

  // Drive a read at the current negedge, push the model's answer, clear rd_val next negedge.
  task automatic issue_read(input int set, input int word);
    bus.rd_val = 1; bus.rd_set = 6'(set); bus.rd_word = 3'(word);
    exp_q.push_back({ref_mem[1][set*8+word], ref_mem[0][set*8+word]});
    @(negedge clk);
    bus.rd_val = 0;
  endtask

  // Full line fill on the inferred instance; called at a negedge, asserts start there.
  task automatic do_fill(input int way, input int set, input int crit, input logic [31:0] base,
                         input int stall_after, input int stall_len, input bit stop_at_done,
                         output int lat, output int ndone, output logic busy_at_done,
                         output logic busy_first);
    int cyc = 0;
    int beat = 0;
    int stalls = 0;
    lat = -1; ndone = 0; busy_at_done = 1'bx; busy_first = 1'bx;
    bus.fill_start = 1; bus.fill_set = 6'(set); bus.fill_way = 1'(way); bus.fill_crit = 3'(crit);
    @(negedge clk);
    cyc = 1;
    bus.fill_start = 0;
    busy_first = bus.fill_busy;
    while (cyc < 40) begin
      if (bus.fill_done) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc;
          busy_at_done = bus.fill_busy;
        end
        if (stop_at_done) break;
      end
      if (beat < 8 && !(beat == stall_after && stalls < stall_len)) begin
        bus.fill_beat_val = 1;
        bus.fill_beat_dat = base + 32'(beat);
        ref_mem[way][set*8 + ((crit + beat) % 8)] = base + 32'(beat);
        beat++;
      end else begin
        bus.fill_beat_val = 0;
        if (beat == stall_after && stalls < stall_len) stalls++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.fill_beat_val = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.rd_dat_val !== 0 || bus.rd_dat !== '0 || bus.fill_busy !== 0 ||
        bus.fill_beat_rdy !== 0 || bus.fill_done !== 0 || bus.rd_rdy !== 1)
      begin errors++; $display("FAIL reset_values: got val=%b dat=%h busy=%b brdy=%b done=%b rdy=%b, want 0 0 0 0 0 1",
        bus.rd_dat_val, bus.rd_dat, bus.fill_busy, bus.fill_beat_rdy, bus.fill_done, bus.rd_rdy); end
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.fill_done !== 0 || bus.fill_busy !== 0 || bus.rd_rdy !== 1 || bus_dr.rd_rdy !== 1)
        begin errors++; $display("FAIL idle_outputs: got done=%b busy=%b rdy=%b rdy_dr=%b, want 0 0 1 1",
          bus.fill_done, bus.fill_busy, bus.rd_rdy, bus_dr.rd_rdy); end
    end
  endtask

  task automatic test_fill_basic();
    int lat, nd;
    logic bd, bf;
    logic [63:0] exp;
    do_fill(0, 5, 0, 32'hC0, -1, 0, 0, lat, nd, bd, bf);
    do_fill(1, 5, 6, 32'hA0, -1, 0, 0, lat, nd, bd, bf);
    checks++;
    if (bf !== 1) begin errors++; $display("FAIL busy_rise: got %b want 1", bf); end
    checks++;
    if (lat !== 9 || nd !== 1 || bd !== 0)
      begin errors++; $display("FAIL fill_done_timing: got lat=%0d pulses=%0d busy=%b, want 9 1 0", lat, nd, bd); end
    for (int i = 0; i < 8; i++) begin
      issue_read(5, i);
      exp = exp_q.pop_front();
      checks++;
      if (bus.rd_dat_val !== 1 || bus.rd_dat !== exp)
        begin errors++; $display("FAIL fill_line word %0d: got val=%b dat=%h, want 1 %h", i, bus.rd_dat_val, bus.rd_dat, exp); end
    end
    issue_read(5, 0);
    exp = exp_q.pop_front();
    checks++;
    if (bus.rd_dat[63:32] !== 32'hA2 || bus.rd_dat[31:0] !== 32'hC0)
      begin errors++; $display("FAIL crit_wrap_word0: got %h want 000000a2000000c0", bus.rd_dat); end
  endtask

  task automatic test_read_hold();
    logic [63:0] exp;
    issue_read(5, 3);
    exp = exp_q.pop_front();
    @(negedge clk);
    checks++;
    if (bus.rd_dat_val !== 0 || bus.rd_dat !== exp)
      begin errors++; $display("FAIL read_hold: got val=%b dat=%h, want 0 %h", bus.rd_dat_val, bus.rd_dat, exp); end
  endtask

  task automatic test_stall();
    int lat, nd;
    logic bd, bf;
    logic [63:0] exp;
    do_fill(1, 5, 6, 32'hA0, 4, 3, 0, lat, nd, bd, bf);
    checks++;
    if (lat !== 12 || nd !== 1 || bd !== 0)
      begin errors++; $display("FAIL stall_done_timing: got lat=%0d pulses=%0d busy=%b, want 12 1 0", lat, nd, bd); end
    for (int i = 0; i < 8; i++) begin
      issue_read(5, i);
      exp = exp_q.pop_front();
      checks++;
      if (bus.rd_dat !== exp || bus.rd_dat[63:32] !== 32'hA0 + 32'((i + 2) % 8))
        begin errors++; $display("FAIL stall_line word %0d: got %h want %h", i, bus.rd_dat, exp); end
    end
  endtask

  task automatic test_rdw();
    logic [63:0] exp;
    bus.fill_start = 1; bus.fill_set = 6'd5; bus.fill_way = 1'b1; bus.fill_crit = 3'd6;
    @(negedge clk);
    bus.fill_start = 0;
    bus.fill_beat_val = 1; bus.fill_beat_dat = 32'hB0;
    ref_mem[1][5*8+6] = 32'hB0;
    issue_read(5, 6);
    bus.fill_beat_val = 0;
    exp = exp_q.pop_front();
    checks++;
    if (bus.rd_dat_val !== 1 || bus.rd_dat !== exp || bus.rd_dat[63:32] !== 32'hB0)
      begin errors++; $display("FAIL read_during_write: got val=%b dat=%h, want 1 %h", bus.rd_dat_val, bus.rd_dat, exp); end
    bus.fill_abort = 1;
    @(negedge clk);
    bus.fill_abort = 0;
  endtask

  task automatic test_abort();
    int nd = 0;
    logic [63:0] exp;
    bus.fill_start = 1; bus.fill_set = 6'd5; bus.fill_way = 1'b1; bus.fill_crit = 3'd0;
    @(negedge clk);
    bus.fill_start = 0;
    for (int b = 0; b < 3; b++) begin
      bus.fill_beat_val = 1; bus.fill_beat_dat = 32'hD0 + 32'(b);
      ref_mem[1][5*8+b] = 32'hD0 + 32'(b);
      // Second start while busy must not retarget the fill
      if (b == 1) begin
        bus.fill_start = 1; bus.fill_set = 6'd9; bus.fill_way = 1'b0; bus.fill_crit = 3'd3;
      end else begin
        bus.fill_start = 0;
      end
      @(negedge clk);
    end
    bus.fill_start = 0;
    bus.fill_abort = 1; bus.fill_beat_val = 1; bus.fill_beat_dat = 32'hD3;
    #1;
    checks++;
    if (bus.fill_beat_rdy !== 0)
      begin errors++; $display("FAIL abort_rdy: got %b want 0", bus.fill_beat_rdy); end
    @(negedge clk);
    checks++;
    if (bus.fill_busy !== 0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.fill_busy); end
    bus.fill_abort = 0; bus.fill_beat_val = 0;
    repeat (6) begin
      if (bus.fill_done === 1) nd++;
      @(negedge clk);
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
    for (int i = 0; i < 8; i++) begin
      issue_read(5, i);
      exp = exp_q.pop_front();
      checks++;
      if (bus.rd_dat !== exp)
        begin errors++; $display("FAIL abort_line word %0d: got %h want %h", i, bus.rd_dat, exp); end
    end
  endtask

  task automatic test_reset_mid_fill();
    int nd = 0;
    logic [63:0] exp;
    bus.fill_start = 1; bus.fill_set = 6'd5; bus.fill_way = 1'b0; bus.fill_crit = 3'd4;
    @(negedge clk);
    bus.fill_start = 0;
    for (int b = 0; b < 2; b++) begin
      bus.fill_beat_val = 1; bus.fill_beat_dat = 32'hF0 + 32'(b);
      ref_mem[0][5*8+4+b] = 32'hF0 + 32'(b);
      @(negedge clk);
    end
    rst = 1; bus.fill_beat_dat = 32'hF2;
    #1;
    checks++;
    if (bus.fill_busy !== 0 || bus.fill_beat_rdy !== 0)
      begin errors++; $display("FAIL reset_mid_fill: got busy=%b brdy=%b want 0 0", bus.fill_busy, bus.fill_beat_rdy); end
    @(negedge clk);
    rst = 0; bus.fill_beat_val = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.fill_done === 1) nd++;
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL reset_no_done: got %0d pulses want 0", nd); end
    for (int i = 0; i < 8; i++) begin
      issue_read(5, i);
      exp = exp_q.pop_front();
      checks++;
      if (bus.rd_dat !== exp)
        begin errors++; $display("FAIL reset_line word %0d: got %h want %h", i, bus.rd_dat, exp); end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, nd1, nd2;
    logic bd, bf;
    logic [63:0] exp;
    do_fill(0, 7, 2, 32'h70, -1, 0, 1, lat1, nd1, bd, bf);
    do_fill(1, 7, 5, 32'h80, -1, 0, 0, lat2, nd2, bd, bf);
    checks++;
    if (lat1 !== 9 || lat2 !== 9 || nd2 !== 1)
      begin errors++; $display("FAIL back_to_back: got lat1=%0d lat2=%0d pulses=%0d, want 9 9 1", lat1, lat2, nd2); end
    for (int i = 0; i < 8; i++) begin
      issue_read(7, i);
      exp = exp_q.pop_front();
      checks++;
      if (bus.rd_dat !== exp)
        begin errors++; $display("FAIL b2b_line word %0d: got %h want %h", i, bus.rd_dat, exp); end
    end
  endtask

  task automatic test_dir_ram();
    int nd = 0;
    logic [31:0] exp;
    bus_dr.fill_start = 1; bus_dr.fill_set = 6'd3; bus_dr.fill_way = 1'b0; bus_dr.fill_crit = 3'd0;
    @(negedge clk);
    bus_dr.fill_start = 0; bus_dr.fill_beat_val = 1; bus_dr.fill_beat_dat = 32'hE0;
    @(negedge clk);
    bus_dr.fill_beat_dat = 32'hE1;
    bus_dr.rd_val = 1; bus_dr.rd_set = 6'd3; bus_dr.rd_word = 3'd0;
    #1;
    checks++;
    if (bus_dr.rd_rdy !== 0) begin errors++; $display("FAIL dr_rdy_blocked: got %b want 0", bus_dr.rd_rdy); end
    @(negedge clk);
    bus_dr.fill_beat_val = 0;
    #1;
    checks++;
    if (bus_dr.rd_dat_val !== 0 || bus_dr.rd_rdy !== 1)
      begin errors++; $display("FAIL dr_retry: got val=%b rdy=%b want 0 1", bus_dr.rd_dat_val, bus_dr.rd_rdy); end
    exp_dr_q.push_back(32'hE0);
    @(negedge clk);
    bus_dr.rd_val = 0;
    exp = exp_dr_q.pop_front();
    checks++;
    if (bus_dr.rd_dat_val !== 1 || bus_dr.rd_dat[31:0] !== exp)
      begin errors++; $display("FAIL dr_retry_data: got val=%b dat=%h want 1 %h", bus_dr.rd_dat_val, bus_dr.rd_dat[31:0], exp); end
    for (int b = 2; b < 8; b++) begin
      bus_dr.fill_beat_val = 1; bus_dr.fill_beat_dat = 32'hE0 + 32'(b);
      @(negedge clk);
    end
    bus_dr.fill_beat_val = 0;
    repeat (3) begin
      if (bus_dr.fill_done === 1) nd++;
      @(negedge clk);
    end
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL dr_done: got %0d pulses want 1", nd); end
    for (int i = 0; i < 8; i++) begin
      bus_dr.rd_val = 1; bus_dr.rd_word = 3'(i);
      exp_dr_q.push_back(32'hE0 + 32'(i));
      @(negedge clk);
      bus_dr.rd_val = 0;
      exp = exp_dr_q.pop_front();
      checks++;
      if (bus_dr.rd_dat_val !== 1 || bus_dr.rd_dat[31:0] !== exp)
        begin errors++; $display("FAIL dr_line word %0d: got %h want %h", i, bus_dr.rd_dat[31:0], exp); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_basic();
    test_read_hold();
    test_stall();
    test_rdw();
    test_abort();
    test_reset_mid_fill();
    test_back_to_back();
    test_dir_ram();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary line");
    $fatal(1);
  end
endmodule
